// File: rtl/excess3_seg_display_if.sv
// Bus between the excess-3 word producer and the display block.
// The master side drives code words; the slave side drives the display pins and error flag.
interface excess3_seg_display_if;
  logic [3:0] z_in;
  logic       z_valid;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       err;

  modport master (output z_in, z_valid, input seg, dp, an, err);
  modport slave  (input z_in, z_valid, output seg, dp, an, err);
endinterface

// File: rtl/excess3_seg_display.sv
// Excess-3 word checker, 4-digit BCD history buffer and multiplexed
// active-low common-anode 7-segment driver. Slot 0 (an[0]) is the newest digit.
module excess3_seg_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  excess3_seg_display_if.slave bus
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [3:0][3:0] digits_q, digits_d;
  logic [2:0]      loaded_q, loaded_d;
  logic            err_q,    err_d;
  logic [PW-1:0]   presc_q,  presc_d;
  logic [1:0]      idx_q,    idx_d;
  logic [6:0]      seg_q,    seg_d;
  logic            dp_q,     dp_d;
  logic [3:0]      an_q,     an_d;
  logic            z_legal;

  // Active-low {g,f,e,d,c,b,a}; non-BCD values stay dark.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Next state: word intake, scan timing, and display outputs from the pre-edge state.
  always_comb begin
    z_legal  = (bus.z_in >= 4'd3) && (bus.z_in <= 4'd12);
    digits_d = digits_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    if (bus.z_valid) begin
      if (z_legal) begin
        digits_d = {digits_q[2:0], bus.z_in - 4'd3};
        loaded_d = (loaded_q == 3'd4) ? 3'd4 : loaded_q + 3'd1;
        err_d    = 1'b0;
      end else begin
        err_d    = 1'b1;
      end
    end
    // Scan step is independent of the intake path above.
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
    end
    an_d  = ~(4'b0001 << idx_q);
    seg_d = ({1'b0, idx_q} < loaded_q) ? decode(digits_q[idx_q]) : 7'h7F;
    dp_d  = !((idx_q == 2'd0) && err_q);
  end

  // State and output registers; reset darkens the display immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      an_q     <= 4'hF;
    end else begin
      digits_q <= digits_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_excess3_seg_display.sv
// Directed bench for excess3_seg_display with a short refresh period.
module tb_excess3_seg_display;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  excess3_seg_display_if bus();

  excess3_seg_display #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Map a one-hot-low anode pattern to its slot number, -1 if malformed.
  function automatic int slot_of(input logic [3:0] a);
    case (a)
      4'b1110: slot_of = 0;
      4'b1101: slot_of = 1;
      4'b1011: slot_of = 2;
      4'b0111: slot_of = 3;
      default: slot_of = -1;
    endcase
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    bus.z_valid = 1'b0;
    bus.z_in = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one word for one edge; returns at the negedge after sampling.
  task automatic strobe(input logic [3:0] w);
    bus.z_in = w;
    bus.z_valid = 1'b1;
    @(negedge clk);
    bus.z_valid = 1'b0;
  endtask

  // Advance to the first negedge on which the given anode pattern appears.
  task automatic wait_slot_start(input logic [3:0] a, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (bus.an === a && n < 40) begin @(negedge clk); n++; end
    while (bus.an !== a && n < 80) begin @(negedge clk); n++; end
    ok = (bus.an === a);
  endtask

  task automatic test_reset;
    logic [3:0] an_seq [5];
    an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    do_reset();
    strobe(4'd0);
    strobe(4'd6);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.seg !== 7'h7F || bus.an !== 4'hF || bus.dp !== 1'b1 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_async seg=%h an=%b dp=%b err=%b want seg=7f an=1111 dp=1 err=0",
               bus.seg, bus.an, bus.dp, bus.err);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus.an !== an_seq[i/4] || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
        failures++;
        $display("FAIL reset_scan cyc=%0d an=%b seg=%h dp=%b want an=%b seg=7f dp=1",
                 i, bus.an, bus.seg, bus.dp, an_seq[i/4]);
      end
    end
  endtask

  task automatic test_single;
    do_reset();
    strobe(4'b0110);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (bus.an === 4'b1110 ? bus.seg !== 7'h30 : bus.seg !== 7'h7F) begin
        failures++;
        $display("FAIL single_digit an=%b seg=%h want %h", bus.an, bus.seg,
                 (bus.an === 4'b1110) ? 7'h30 : 7'h7F);
      end
    end
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL single_err err=%b want 0", bus.err);
    end
  endtask

  task automatic test_multi;
    logic [6:0] e1 [4];
    logic [6:0] e2 [4];
    int s;
    e1 = '{7'h10, 7'h24, 7'h79, 7'h40};
    e2 = '{7'h19, 7'h10, 7'h24, 7'h79};
    strobe(4'd3); strobe(4'd4); strobe(4'd5); strobe(4'd12);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s = slot_of(bus.an);
      checks++;
      if (s < 0 || bus.seg !== e1[s]) begin
        failures++;
        $display("FAIL multi_fill an=%b seg=%h want %h", bus.an, bus.seg, (s < 0) ? 7'h7F : e1[s]);
      end
    end
    strobe(4'd7);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s = slot_of(bus.an);
      checks++;
      if (s < 0 || bus.seg !== e2[s]) begin
        failures++;
        $display("FAIL multi_shift an=%b seg=%h want %h", bus.an, bus.seg, (s < 0) ? 7'h7F : e2[s]);
      end
    end
  endtask

  task automatic test_error;
    logic [6:0] e1 [4];
    logic [6:0] e2 [4];
    int s;
    e1 = '{7'h19, 7'h10, 7'h24, 7'h79};
    e2 = '{7'h12, 7'h19, 7'h10, 7'h24};
    strobe(4'b1111);
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL err_set err=%b want 1", bus.err);
    end
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s = slot_of(bus.an);
      checks++;
      if (s < 0 || bus.seg !== e1[s] || bus.dp !== (s != 0)) begin
        failures++;
        $display("FAIL err_hold an=%b seg=%h dp=%b want seg=%h dp=%b", bus.an, bus.seg, bus.dp,
                 (s < 0) ? 7'h7F : e1[s], (s != 0));
      end
    end
    strobe(4'd8);
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear err=%b want 0", bus.err);
    end
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s = slot_of(bus.an);
      checks++;
      if (s < 0 || bus.seg !== e2[s] || bus.dp !== 1'b1) begin
        failures++;
        $display("FAIL err_recover an=%b seg=%h dp=%b want seg=%h dp=1", bus.an, bus.seg, bus.dp,
                 (s < 0) ? 7'h7F : e2[s]);
      end
    end
  endtask

  task automatic test_wrap_err;
    bit ok;
    wait_slot_start(4'b0111, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wrap_wait an=%b want 0111 within budget", bus.an);
    end
    @(negedge clk);
    @(negedge clk);
    strobe(4'b0010);
    checks++;
    if (bus.err !== 1'b1 || bus.an !== 4'b0111) begin
      failures++;
      $display("FAIL wrap_strobe err=%b an=%b want err=1 an=0111", bus.err, bus.an);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.an !== 4'b1110 || bus.seg !== 7'h12 || bus.dp !== 1'b0) begin
        failures++;
        $display("FAIL wrap_slot0 cyc=%0d an=%b seg=%h dp=%b want an=1110 seg=12 dp=0",
                 i, bus.an, bus.seg, bus.dp);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.an !== 4'b1101 || bus.seg !== 7'h19 || bus.dp !== 1'b1) begin
      failures++;
      $display("FAIL wrap_slot1 an=%b seg=%h dp=%b want an=1101 seg=19 dp=1",
               bus.an, bus.seg, bus.dp);
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] e [4];
    int s;
    e = '{7'h12, 7'h19, 7'h30, 7'h24};
    do_reset();
    for (int w = 3; w <= 8; w++) strobe(4'(w));
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_err err=%b want 0", bus.err);
    end
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s = slot_of(bus.an);
      checks++;
      if (s < 0 || bus.seg !== e[s]) begin
        failures++;
        $display("FAIL b2b_digits an=%b seg=%h want %h", bus.an, bus.seg, (s < 0) ? 7'h7F : e[s]);
      end
    end
  endtask

  initial begin
    bus.z_in = 4'd0;
    bus.z_valid = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_error();
    test_wrap_err();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
